// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter.
// Status bit positions, serialiser states and a constant log2 helper.
package uart_tx_fifo_pkg;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_FLUSH     = 4;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/flush and occupancy count.
// Ports: clk, rst_n, push, pop, flush, din, dout (head), full, empty, count.
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      cnt;
  logic             do_pop;
  logic             do_push;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) cnt <= cnt + 1'b1;
      else if (!do_push && do_pop) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter on the reg_state/reg_dat strobe bus.
// Ports: clk, resetn, ser_tx, reg_state_* (status/control), reg_dat_* (push).
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int UART_CLK   = 12000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ser_tx,
  input  logic        reg_state_we,
  input  logic        reg_state_re,
  input  logic [31:0] reg_state_di,
  output logic [31:0] reg_state_do,
  output logic        reg_state_wait,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait
);

  localparam int CLK_DIV = UART_CLK / BAUD_RATE;
  localparam int CDW     = clog2(CLK_DIV);
  localparam int CW      = clog2(FIFO_DEPTH) + 1;

  tx_state_t      state;
  tx_state_t      state_n;
  logic [CDW-1:0] baud;
  logic [CDW-1:0] baud_n;
  logic [2:0]     bit_idx;
  logic [2:0]     bit_idx_n;
  logic [7:0]     shift;
  logic [7:0]     shift_n;
  logic           ser_n;
  logic           bit_end;
  logic           pop;
  logic           flush;
  logic           ovf;
  logic           dropped;
  logic [7:0]     f_dout;
  logic           f_full;
  logic           f_empty;
  logic [CW-1:0]  f_count;
  logic           unused;

  assign unused = ^{reg_state_re, reg_dat_re, reg_state_di[31:5],
                    reg_state_di[2:0], reg_dat_di[31:8]};

  assign reg_state_wait = 1'b0;
  assign reg_dat_wait   = 1'b0;
  assign reg_dat_do     = 32'h0;

  assign flush   = reg_state_we && reg_state_di[ST_FLUSH];
  assign dropped = reg_dat_we && !flush && f_full && !pop;
  assign bit_end = (baud == CDW'(CLK_DIV - 1));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (resetn),
    .push  (reg_dat_we),
    .pop   (pop),
    .flush (flush),
    .din   (reg_dat_di[7:0]),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  always_comb begin
    state_n   = state;
    baud_n    = baud + 1'b1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    unique case (state)
      S_IDLE: begin
        baud_n = '0;
        if (!f_empty) begin
          pop     = 1'b1;
          shift_n = f_dout;
          state_n = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_n    = '0;
          bit_idx_n = 3'd0;
          state_n   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_n    = '0;
          shift_n   = shift >> 1;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_n = '0;
          // Chain straight into the next start bit: no idle gap.
          if (!f_empty) begin
            pop     = 1'b1;
            shift_n = f_dout;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Line level follows the next state so ser_tx comes straight from a flop.
  always_comb begin
    ser_n = 1'b1;
    unique case (state_n)
      S_START: ser_n = 1'b0;
      S_DATA:  ser_n = shift_n[0];
      default: ser_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      ser_tx  <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      ser_tx  <= ser_n;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf <= 1'b0;
    end else if (dropped) begin
      ovf <= 1'b1;
    end else if (reg_state_we && reg_state_di[ST_OVF]) begin
      ovf <= 1'b0;
    end
  end

  always_comb begin
    reg_state_do = 32'h0;
    reg_state_do[ST_BUSY]  = !f_empty || (state != S_IDLE);
    reg_state_do[ST_FULL]  = f_full;
    reg_state_do[ST_EMPTY] = f_empty;
    reg_state_do[ST_OVF]   = ovf;
    reg_state_do[ST_COUNT_LSB +: CW] = f_count;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo at default parameters.
// Frames are checked cycle by cycle against a byte-queue model.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  localparam int CLK_DIV = 12000000 / 115200;
  localparam int FRAME   = 10 * CLK_DIV;
  localparam int DEPTH   = 16;

  logic        clk;
  logic        resetn;
  logic        ser_tx;
  logic        reg_state_we;
  logic        reg_state_re;
  logic [31:0] reg_state_di;
  logic [31:0] reg_state_do;
  logic        reg_state_wait;
  logic        reg_dat_we;
  logic        reg_dat_re;
  logic [31:0] reg_dat_di;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

  uart_tx_fifo dut (
    .clk            (clk),
    .resetn         (resetn),
    .ser_tx         (ser_tx),
    .reg_state_we   (reg_state_we),
    .reg_state_re   (reg_state_re),
    .reg_state_di   (reg_state_di),
    .reg_state_do   (reg_state_do),
    .reg_state_wait (reg_state_wait),
    .reg_dat_we     (reg_dat_we),
    .reg_dat_re     (reg_dat_re),
    .reg_dat_di     (reg_dat_di),
    .reg_dat_do     (reg_dat_do),
    .reg_dat_wait   (reg_dat_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input int busy, input int full,
                                     input int empty, input int ovf,
                                     input int cnt);
    return 32'(busy + 2 * full + 4 * empty + 8 * ovf + 256 * cnt);
  endfunction

  task automatic tick();
    @(negedge clk);
    reg_state_re = 1'($urandom);
    reg_dat_re   = 1'($urandom);
  endtask

  task automatic wr_dat(input logic [7:0] b);
    reg_dat_di = {24'($urandom), b};
    reg_dat_we = 1'b1;
    tick();
    reg_dat_we = 1'b0;
  endtask

  task automatic wr_state(input logic [31:0] v);
    reg_state_di = v;
    reg_state_we = 1'b1;
    tick();
    reg_state_we = 1'b0;
    reg_state_di = 32'h0;
  endtask

  task automatic no_tx(input int n, input string tag);
    logic ok;
    ok = 1'b1;
    repeat (n) begin
      if (ser_tx !== 1'b1) ok = 1'b0;
      tick();
    end
    chk(tag, {31'b0, ok}, 32'h1);
  endtask

  // Starts at frame cycle 'skip' (cycle 0 = first start-bit cycle) and
  // returns on the first cycle after the stop bit.
  task automatic rx_frame(input logic [7:0] b, input int skip,
                          input bit push_end, input logic [7:0] pb);
    logic [9:0] fr;
    bit         seen [10];
    bit         bad  [10];
    logic       val  [10];
    int         k;
    fr = {1'b1, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      seen[j] = 0;
      bad[j]  = 0;
      val[j]  = fr[j];
    end
    for (int i = skip; i < FRAME; i++) begin
      k = i / CLK_DIV;
      seen[k] = 1;
      if (!bad[k] && ser_tx !== fr[k]) begin
        bad[k] = 1;
        val[k] = ser_tx;
      end
      if (i == FRAME - 1) begin
        chk("busy_last_stop", {31'b0, reg_state_do[ST_BUSY]}, 32'h1);
        if (push_end) begin
          reg_dat_di = {24'($urandom), pb};
          reg_dat_we = 1'b1;
        end
      end
      tick();
      reg_dat_we = 1'b0;
    end
    for (int j = 0; j < 10; j++) begin
      if (seen[j])
        chk($sformatf("frame_%02h_bit%0d", b, j), {31'b0, val[j]},
            {31'b0, fr[j]});
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] pb;
    int occ;
    int ovf_m;
    int n;
    int el;
    int gap;
    bit popped;
    bit acc;

    resetn       = 1'b0;
    reg_state_we = 1'b0;
    reg_state_re = 1'b0;
    reg_state_di = 32'h0;
    reg_dat_we   = 1'b0;
    reg_dat_re   = 1'b0;
    reg_dat_di   = 32'h0;
    repeat (3) tick();
    chk("reset_ser", {31'b0, ser_tx}, 32'h1);
    chk("reset_status", reg_state_do, st(0, 0, 1, 0, 0));
    chk("dat_do", reg_dat_do, 32'h0);
    chk("waits", {30'b0, reg_state_wait, reg_dat_wait}, 32'h0);
    resetn = 1'b1;
    tick();

    // Single byte, latency and exact bit timing.
    wr_dat(8'h55);
    chk("t1_ser_n1", {31'b0, ser_tx}, 32'h1);
    chk("t1_st_n1", reg_state_do, st(1, 0, 0, 0, 1));
    tick();
    chk("t1_st_n2", reg_state_do, st(1, 0, 1, 0, 0));
    rx_frame(8'h55, 0, 0, 8'h00);
    chk("t1_idle", reg_state_do, st(0, 0, 1, 0, 0));

    // Three back-to-back frames.
    wr_dat(8'h41);
    wr_dat(8'h42);
    wr_dat(8'h43);
    chk("t2_cnt2", reg_state_do, st(1, 0, 0, 0, 2));
    rx_frame(8'h41, 1, 0, 8'h00);
    rx_frame(8'h42, 0, 0, 8'h00);
    rx_frame(8'h43, 0, 0, 8'h00);
    chk("t2_idle", reg_state_do, st(0, 0, 1, 0, 0));
    no_tx(20, "t2_no_extra");

    // Overflow: 18 writes back to back from idle.
    occ   = 0;
    ovf_m = 0;
    q.delete();
    for (int i = 0; i < 18; i++) begin
      b      = 8'($urandom);
      popped = (i == 1);
      acc    = (occ < DEPTH) || popped;
      if (acc) q.push_back(b);
      else ovf_m = 1;
      occ = occ - int'(popped) + int'(acc);
      wr_dat(b);
      if (i == 16)
        chk("t3_full", reg_state_do, st(1, 1, 0, ovf_m, occ));
    end
    chk("t3_ovf", reg_state_do, st(1, 1, 0, ovf_m, occ));
    wr_state(32'h08);
    chk("t3_ovf_clr", reg_state_do, st(1, 1, 0, 0, occ));

    // Push coincident with pop at the end of the stop bit.
    pb = 8'($urandom);
    rx_frame(q.pop_front(), 17, 1, pb);
    q.push_back(pb);
    chk("t5_coinc", reg_state_do, st(1, 1, 0, 0, DEPTH));

    // Flush mid-frame: current frame completes, nothing follows.
    wr_state(32'h10);
    chk("t4_flushed", reg_state_do, st(1, 0, 1, 0, 0));
    rx_frame(q.pop_front(), 1, 0, 8'h00);
    q.delete();
    chk("t4_idle", reg_state_do, st(0, 0, 1, 0, 0));
    no_tx(3 * CLK_DIV, "t4_no_more");

    // Flush and push in the same cycle: byte is discarded.
    reg_dat_di   = 32'h0000_00A5;
    reg_dat_we   = 1'b1;
    reg_state_di = 32'h10;
    reg_state_we = 1'b1;
    tick();
    reg_dat_we   = 1'b0;
    reg_state_we = 1'b0;
    chk("t6_flush_wins", reg_state_do, st(0, 0, 1, 0, 0));
    no_tx(10, "t6_no_tx");

    // Random bursts with random gaps.
    for (int r = 0; r < 4; r++) begin
      n  = $urandom_range(1, 16);
      el = 0;
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        q.push_back(b);
        wr_dat(b);
        el++;
        gap = $urandom_range(0, 3);
        repeat (gap) begin
          tick();
          el++;
        end
      end
      if (el < 2) begin
        tick();
        el++;
      end
      rx_frame(q.pop_front(), el - 2, 0, 8'h00);
      while (q.size() > 0) rx_frame(q.pop_front(), 0, 0, 8'h00);
      chk($sformatf("rnd%0d_idle", r), reg_state_do, st(0, 0, 1, 0, 0));
    end

    // Reset in the middle of data bit 3.
    wr_dat(8'h00);
    tick();
    repeat (4 * CLK_DIV + 50) tick();
    chk("t7_pre_rst", {31'b0, ser_tx}, 32'h0);
    #2 resetn = 1'b0;
    #1;
    chk("t7_async_ser", {31'b0, ser_tx}, 32'h1);
    chk("t7_async_st", reg_state_do, st(0, 0, 1, 0, 0));
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("t7_post_st", reg_state_do, st(0, 0, 1, 0, 0));
    chk("t7_post_ser", {31'b0, ser_tx}, 32'h1);
    wr_dat(8'h3C);
    tick();
    rx_frame(8'h3C, 0, 0, 8'h00);
    chk("t7_idle", reg_state_do, st(0, 0, 1, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
